// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: registered one-hot grant with a rotating priority pointer.
// Optional hold-time limit with forced release is enabled by defining RR_SCHED_TIMEOUT_EN.
module rr_grant_scheduler #(
    parameter int IDX_W    = 4,
    parameter int NUM_REQ  = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               timeout_o
);

    if (NUM_REQ != 2**IDX_W || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
        $error("rr_grant_scheduler: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
`ifdef RR_SCHED_TIMEOUT_EN
    logic [7:0]         hold_q, hold_d;
    logic               forced;
`endif

    logic [IDX_W-1:0]   arb_start;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;
    logic               release_now;

    // Lowest offset from the start index wins, so scan downward and let the last hit stand.
    always_comb begin
        arb_start = (state_q == GRANT) ? gnt_idx_q + 1'b1 : ptr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[arb_start + IDX_W'(i)]) begin
                arb_found = 1'b1;
                arb_idx   = arb_start + IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        release_now = 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
        hold_d      = hold_q;
        forced      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << arb_idx;
                    gnt_idx_d   = arb_idx;
                    gnt_valid_d = 1'b1;
`ifdef RR_SCHED_TIMEOUT_EN
                    hold_d      = 8'd1;
`endif
                end
            end
            GRANT: begin
                release_now = !req_i[gnt_idx_q];
`ifdef RR_SCHED_TIMEOUT_EN
                forced      = req_i[gnt_idx_q] && (hold_q == 8'(MAX_HOLD));
                release_now = release_now || forced;
                timeout_d   = forced;
`endif
                if (release_now) begin
                    ptr_d = gnt_idx_q + 1'b1;
                    if (arb_found) begin
                        gnt_d       = NUM_REQ'(1) << arb_idx;
                        gnt_idx_d   = arb_idx;
                        gnt_valid_d = 1'b1;
`ifdef RR_SCHED_TIMEOUT_EN
                        hold_d      = 8'd1;
`endif
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
                        hold_d      = 8'd0;
`endif
                    end
                end else begin
`ifdef RR_SCHED_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
            hold_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
`ifdef RR_SCHED_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
`ifdef RR_SCHED_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: vector table plus multi-cycle corner sequences.
// The timeout sequence follows whichever build of RR_SCHED_TIMEOUT_EN is compiled.
module tb_rr_grant_scheduler;

    logic        clk;
    logic        reset;
    logic [15:0] req_i;
    logic [15:0] gnt_o;
    logic [3:0]  gnt_idx_o;
    logic        gnt_valid_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    rr_grant_scheduler #(
        .IDX_W   (4),
        .NUM_REQ (16),
        .MAX_HOLD(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .gnt_idx_o  (gnt_idx_o),
        .gnt_valid_o(gnt_valid_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        valid;
        logic [3:0]  idx;
    } vec_t;

    vec_t vecs[12];

    task automatic applyStimulus(input logic [15:0] r);
        @(negedge clk);
        req_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [3:0] ei,
                               input logic et);
        logic [15:0] eg;
        eg = ev ? (16'h0001 << ei) : 16'h0000;
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== {eg, ei, ev, et}) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, expected gnt=%h idx=%0d valid=%b timeout=%b",
                     name, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o, eg, ei, ev, et);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        req_i = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Grant/index consistency must hold on every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(gnt_o) || (gnt_valid_o != (gnt_o != 16'h0)) ||
                (gnt_valid_o && gnt_o != (16'h0001 << gnt_idx_o)) ||
                (!gnt_valid_o && gnt_idx_o != 4'd0)) begin
                errors++;
                $display("[TB] FAIL onehot_consistency: got gnt=%h idx=%0d valid=%b, expected one-hot decode of idx when valid",
                         gnt_o, gnt_idx_o, gnt_valid_o);
            end
        end
    end

    initial begin
        vecs[0]  = '{16'h0000, 1'b0, 4'd0};
        vecs[1]  = '{16'h0010, 1'b1, 4'd4};
        vecs[2]  = '{16'h0011, 1'b1, 4'd4};
        vecs[3]  = '{16'h0001, 1'b1, 4'd0};
        vecs[4]  = '{16'h0000, 1'b0, 4'd0};
        vecs[5]  = '{16'h0003, 1'b1, 4'd1};
        vecs[6]  = '{16'h0001, 1'b1, 4'd0};
        vecs[7]  = '{16'h8000, 1'b1, 4'd15};
        vecs[8]  = '{16'h0003, 1'b1, 4'd0};
        vecs[9]  = '{16'h0000, 1'b0, 4'd0};
        vecs[10] = '{16'h0001, 1'b1, 4'd0};
        vecs[11] = '{16'h0000, 1'b0, 4'd0};

        reset = 1'b1;
        req_i = 16'h0000;
        #12;
        checkOutput("reset_state", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].valid, vecs[i].idx, 1'b0);
        end

        $display("[TB] same-cycle release and request");
        applyStimulus(16'h0008);
        checkOutput("same_grant3", 1'b1, 4'd3, 1'b0);
        applyStimulus(16'h0008);
        checkOutput("same_hold3", 1'b1, 4'd3, 1'b0);
        applyStimulus(16'h0200);
        checkOutput("same_grant9", 1'b1, 4'd9, 1'b0);

        $display("[TB] asynchronous reset mid-grant");
        #3;
        reset = 1'b1;
        req_i = 16'h0000;
        #1;
        checkOutput("reset_async", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(16'h8001);
        checkOutput("reset_search0", 1'b1, 4'd0, 1'b0);
        applyStimulus(16'h0000);
        checkOutput("reset_release", 1'b0, 4'd0, 1'b0);

        $display("[TB] idle cycles");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'h0000);
            checkOutput($sformatf("idle%0d", i), 1'b0, 4'd0, 1'b0);
        end
        applyStimulus(16'h8001);
        checkOutput("idle_ptr_kept", 1'b1, 4'd15, 1'b0);

        $display("[TB] rotation");
        doReset();
        applyStimulus(16'hFFFF);
        checkOutput("rot_first", 1'b1, 4'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(16'hFFFF);
            checkOutput($sformatf("rot_hold%0d", k), 1'b1, 4'(k), 1'b0);
            applyStimulus(16'hFFFF & ~(16'h0001 << k));
            checkOutput($sformatf("rot_next%0d", k), 1'b1, 4'((k + 1) % 16), 1'b0);
        end

        $display("[TB] hold limit");
        doReset();
`ifdef RR_SCHED_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            applyStimulus(16'h0012);
            checkOutput($sformatf("to_idx1_%0d", c), 1'b1, 4'd1, 1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(16'h0012);
            checkOutput($sformatf("to_idx4_%0d", c), 1'b1, 4'd4, (c == 0));
        end
        applyStimulus(16'h0012);
        checkOutput("to_back_idx1", 1'b1, 4'd1, 1'b1);
`else
        for (int c = 0; c < 20; c++) begin
            applyStimulus(16'h0012);
            checkOutput($sformatf("hold_idx1_%0d", c), 1'b1, 4'd1, 1'b0);
        end
`endif

        applyStimulus(16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, default 4: width of the binary grant index.
REQ-002 SHALL have parameter NUM_REQ, default 16: requester count; NUM_REQ SHALL equal 2**IDX_W.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles, used only when RR_SCHED_TIMEOUT_EN is defined; legal range 2..255.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, NUM_REQ: per-requester request, level-held until done.
REQ-007 SHALL have port gnt_o, output, NUM_REQ: registered one-hot grant, or all-zero.
REQ-008 SHALL have port gnt_idx_o, output, IDX_W: binary index of the granted requester; 0 when gnt_valid_o is low.
REQ-009 SHALL have port gnt_valid_o, output, 1: high exactly when gnt_o is nonzero.
REQ-010 SHALL have port timeout_o, output, 1: one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and GRANT, with a rotating priority pointer ptr of IDX_W bits.
REQ-012 In IDLE, if any req_i bit is high at edge N, the FSM SHALL enter GRANT, and gnt_o SHALL show the winner from edge N, one-cycle latency.
REQ-013 Winner SHALL be the first set req_i bit found searching upward from ptr, wrapping from NUM_REQ-1 to 0.
REQ-014 gnt_o SHALL always equal the one-hot decode of gnt_idx_o when gnt_valid_o is high; gnt_o SHALL never have more than one bit set.
REQ-015 In GRANT, the grant SHALL hold unchanged while req_i[gnt_idx_o] stays high; other requests SHALL NOT preempt it.
REQ-016 When req_i[gnt_idx_o] is low at an edge (release), ptr SHALL become gnt_idx_o+1 mod NUM_REQ.
REQ-017 At a release edge, the scheduler SHALL arbitrate among the other requests from gnt_idx_o+1. If any are set, it SHALL stay in GRANT with the new winner, with no bubble cycle. Otherwise it SHALL go to IDLE with gnt_o all-zero.
REQ-018 A request rising in the same cycle as a release SHALL be eligible in that release's arbitration.
REQ-019 In IDLE with req_i all-zero, the outputs SHALL stay at zero and ptr SHALL stay unchanged.

Reset
REQ-020 While reset is high, asynchronously and regardless of clk: state=IDLE, ptr=0, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, and the hold counter=0.
REQ-021 Reset asserted mid-grant SHALL drop the grant immediately. The first arbitration after deassertion SHALL search from index 0.

Configuration
REQ-022 With RR_SCHED_TIMEOUT_EN defined, an 8-bit hold counter SHALL reset to 1 on each new grant and increment each cycle the grant is held.
REQ-023 With RR_SCHED_TIMEOUT_EN defined, at the edge where the counter equals MAX_HOLD and the granted request is still high, the grant SHALL be force-released.
REQ-024 A forced release SHALL set ptr to gnt_idx_o+1, pulse timeout_o for one cycle, and rearbitrate per REQ-017. If only the same requester is requesting, it SHALL be re-granted with the counter reset to 1.
REQ-025 Without RR_SCHED_TIMEOUT_EN, the hold counter and forced-release logic SHALL be absent, timeout_o SHALL be tied to 0, and grants SHALL be held indefinitely.

Verification
REQ-026 Reset scenario: reset high mid-grant -> all outputs 0 within the same cycle. After release, req_i=16'h8001 -> gnt_idx_o=0.
REQ-027 Rotation scenario: req_i=16'hFFFF, each grantee drops its request for one cycle after 2 granted cycles -> gnt_idx_o sequence 0,1,2,...,15,0 with no idle cycle between grants.
REQ-028 Wrap scenario: grant idx 15 released with req_i=16'h0003 -> next cycle gnt_idx_o=0, gnt_o=16'h0001.
REQ-029 Same-cycle scenario: idx 3 releases while req_i[9] rises in the same cycle with no other requests -> gnt_idx_o=9 next cycle, gnt_valid_o stays high throughout.
REQ-030 Timeout scenario: with RR_SCHED_TIMEOUT_EN, MAX_HOLD=8 and req_i=16'h0012 held constant -> idx1 granted for 8 cycles, one timeout_o pulse, then idx4 granted for 8 cycles, then idx1. Without the macro -> idx1 held indefinitely and timeout_o stays 0.
REQ-031 Idle scenario: req_i=0 for 10 cycles -> gnt_valid_o=0 throughout and ptr unchanged. One-hot and index consistency SHALL be checked by assertion every cycle.
